// File: rtl/rrf_writeback_unit_pkg.sv
// Shared constants and types for the rename register file writeback unit.
// Build option RRF_WB_BYPASS_EN enables same-cycle writeback bypass on reads.
package rrf_writeback_unit_pkg;
   localparam int RRF_NUM  = 64;
   localparam int RRF_SEL  = 6;
   localparam int DATA_LEN = 32;

   typedef logic [RRF_SEL-1:0]  tag_t;
   typedef logic [DATA_LEN-1:0] data_t;
   typedef logic [RRF_SEL:0]    cnt_t;

   // 2-bit count encoding shared by alloc_req and com_num
   typedef enum logic [1:0] {
      CNT_NONE = 2'd0,
      CNT_ONE  = 2'd1,
      CNT_TWO  = 2'd2,
      CNT_BAD  = 2'd3
   } cnt2_e;
endpackage

// File: rtl/rrf_writeback_unit_if.sv
// Allocation, writeback, operand-read and commit bundle of the RRF.
// master = dispatch/execute/commit side, slave = the RRF writeback unit.
interface rrf_writeback_unit_if;
   import rrf_writeback_unit_pkg::*;

   logic       stall_dp;
   logic [1:0] alloc_req;
   logic       alloc_ok;
   tag_t       alloc_tag1, alloc_tag2;
   cnt_t       freenum;

   logic       wb_en1, wb_en2;
   tag_t       wb_tag1, wb_tag2;
   data_t      wb_data1, wb_data2;

   tag_t       rd_tag0, rd_tag1, rd_tag2, rd_tag3;
   logic       rd_valid0, rd_valid1, rd_valid2, rd_valid3;
   data_t      rd_data0, rd_data1, rd_data2, rd_data3;

   logic [1:0] com_num;
   tag_t       comptr;
   logic       com_rdy1, com_rdy2;
   data_t      com_data1, com_data2;

   modport master (
      output stall_dp, alloc_req, wb_en1, wb_en2,
      output wb_tag1, wb_tag2, wb_data1, wb_data2,
      output rd_tag0, rd_tag1, rd_tag2, rd_tag3, com_num,
      input  alloc_ok, alloc_tag1, alloc_tag2, freenum,
      input  rd_valid0, rd_valid1, rd_valid2, rd_valid3,
      input  rd_data0, rd_data1, rd_data2, rd_data3,
      input  comptr, com_rdy1, com_rdy2, com_data1, com_data2
   );

   modport slave (
      input  stall_dp, alloc_req, wb_en1, wb_en2,
      input  wb_tag1, wb_tag2, wb_data1, wb_data2,
      input  rd_tag0, rd_tag1, rd_tag2, rd_tag3, com_num,
      output alloc_ok, alloc_tag1, alloc_tag2, freenum,
      output rd_valid0, rd_valid1, rd_valid2, rd_valid3,
      output rd_data0, rd_data1, rd_data2, rd_data3,
      output comptr, com_rdy1, com_rdy2, com_data1, com_data2
   );
endinterface

// File: rtl/rrf_read_port.sv
// One RRF read port: tag mux over valid/data, optional writeback bypass.
// Bypass compare is present only when RRF_WB_BYPASS_EN is defined.
module rrf_read_port
   import rrf_writeback_unit_pkg::*;
(
   input  tag_t               tag_i,
   input  logic [RRF_NUM-1:0] valid_i,
   input  data_t              mem_i [RRF_NUM],
   input  logic               wb_en1_i,
   input  tag_t               wb_tag1_i,
   input  data_t              wb_data1_i,
   input  logic               wb_en2_i,
   input  tag_t               wb_tag2_i,
   input  data_t              wb_data2_i,
   output logic               valid_o,
   output data_t              data_o
);
`ifdef RRF_WB_BYPASS_EN
   always_comb begin
      valid_o = valid_i[tag_i];
      data_o  = mem_i[tag_i];
      if (wb_en1_i && wb_tag1_i == tag_i) begin
         valid_o = 1'b1;
         data_o  = wb_data1_i;
      end
      // port 2 checked last so it wins, matching the array write order
      if (wb_en2_i && wb_tag2_i == tag_i) begin
         valid_o = 1'b1;
         data_o  = wb_data2_i;
      end
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_en1_i, wb_tag1_i, wb_data1_i,
                        wb_en2_i, wb_tag2_i, wb_data2_i};
   assign valid_o = valid_i[tag_i];
   assign data_o  = mem_i[tag_i];
`endif
endmodule

// File: rtl/rrf_writeback_unit.sv
// RRF write side: tag allocation, writeback capture, in-order retirement.
// Define RRF_WB_BYPASS_EN for same-cycle writeback-to-read bypass.
module rrf_writeback_unit
   import rrf_writeback_unit_pkg::*;
(
   input logic                 clk,
   input logic                 reset_n,
   rrf_writeback_unit_if.slave bus
);
   data_t              mem_q [RRF_NUM];
   logic [RRF_NUM-1:0] valid_q, valid_d;
   tag_t               rrfptr_q, rrfptr_d;
   tag_t               comptr_q, comptr_d;
   cnt_t               freenum_q, freenum_d;
   cnt_t               req_n, com_n, alloc_n;
   logic               alloc_fire;
   logic [1:0]         wb_hit;

   assign req_n      = cnt_t'(bus.alloc_req);
   assign com_n      = cnt_t'(bus.com_num);
   assign bus.alloc_ok = freenum_q >= req_n;
   assign alloc_fire = ~bus.stall_dp & bus.alloc_ok &
                       (bus.alloc_req != CNT_NONE);
   assign alloc_n    = alloc_fire ? req_n : '0;

   assign bus.alloc_tag1 = rrfptr_q;
   assign bus.alloc_tag2 = rrfptr_q + tag_t'(1);
   assign bus.freenum    = freenum_q;
   assign bus.comptr     = comptr_q;

   // Commit leaves valid set; reallocation is what clears an entry
   always_comb begin
      valid_d = valid_q;
      if (bus.wb_en1) valid_d[bus.wb_tag1] = 1'b1;
      if (bus.wb_en2) valid_d[bus.wb_tag2] = 1'b1;
      if (alloc_fire) valid_d[bus.alloc_tag1] = 1'b0;
      if (alloc_fire && bus.alloc_req == CNT_TWO)
         valid_d[bus.alloc_tag2] = 1'b0;
      rrfptr_d  = rrfptr_q + tag_t'(alloc_n);
      comptr_d  = comptr_q + tag_t'(com_n);
      freenum_d = freenum_q - alloc_n + com_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= '0;
         rrfptr_q  <= '0;
         comptr_q  <= '0;
         freenum_q <= cnt_t'(RRF_NUM);
      end else begin
         valid_q   <= valid_d;
         rrfptr_q  <= rrfptr_d;
         comptr_q  <= comptr_d;
         freenum_q <= freenum_d;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.wb_en1) mem_q[bus.wb_tag1] <= bus.wb_data1;
      if (bus.wb_en2) mem_q[bus.wb_tag2] <= bus.wb_data2;
   end

   tag_t  rtag [6];
   logic  rval [6];
   data_t rdat [6];

   assign rtag[0] = bus.rd_tag0;
   assign rtag[1] = bus.rd_tag1;
   assign rtag[2] = bus.rd_tag2;
   assign rtag[3] = bus.rd_tag3;
   assign rtag[4] = comptr_q;
   assign rtag[5] = comptr_q + tag_t'(1);

   for (genvar i = 0; i < 6; i++) begin : g_rd
      rrf_read_port u_rd (
         .tag_i      (rtag[i]),
         .valid_i    (valid_q),
         .mem_i      (mem_q),
         .wb_en1_i   (bus.wb_en1),
         .wb_tag1_i  (bus.wb_tag1),
         .wb_data1_i (bus.wb_data1),
         .wb_en2_i   (bus.wb_en2),
         .wb_tag2_i  (bus.wb_tag2),
         .wb_data2_i (bus.wb_data2),
         .valid_o    (rval[i]),
         .data_o     (rdat[i])
      );
   end

   assign bus.rd_valid0 = rval[0];
   assign bus.rd_valid1 = rval[1];
   assign bus.rd_valid2 = rval[2];
   assign bus.rd_valid3 = rval[3];
   assign bus.rd_data0  = rdat[0];
   assign bus.rd_data1  = rdat[1];
   assign bus.rd_data2  = rdat[2];
   assign bus.rd_data3  = rdat[3];
   assign bus.com_rdy1  = rval[4];
   assign bus.com_rdy2  = rval[5];
   assign bus.com_data1 = rdat[4];
   assign bus.com_data2 = rdat[5];

   always_comb begin
      wb_hit = '0;
      if (alloc_fire) begin
         wb_hit[0] = bus.wb_en1 && (bus.wb_tag1 == bus.alloc_tag1 ||
            (bus.alloc_req == CNT_TWO && bus.wb_tag1 == bus.alloc_tag2));
         wb_hit[1] = bus.wb_en2 && (bus.wb_tag2 == bus.alloc_tag1 ||
            (bus.alloc_req == CNT_TWO && bus.wb_tag2 == bus.alloc_tag2));
      end
   end

   a_req_legal: assert property (@(posedge clk) disable iff (!reset_n)
      bus.alloc_req != CNT_BAD);
   a_wb_same_tag: assert property (@(posedge clk) disable iff (!reset_n)
      !(bus.wb_en1 && bus.wb_en2 && bus.wb_tag1 == bus.wb_tag2));
   a_wb_to_alloc: assert property (@(posedge clk) disable iff (!reset_n)
      wb_hit == 2'b00);
   a_com_legal: assert property (@(posedge clk) disable iff (!reset_n)
      com_n <= cnt_t'(rval[4]) + cnt_t'(rval[5]));
   a_free_range: assert property (@(posedge clk) disable iff (!reset_n)
      freenum_q <= cnt_t'(RRF_NUM));
endmodule
